// File: rtl/err_calc_resp.sv
// err_calc_resp: residual err = y - (b0 + b1*x) for the regression error phase.
// Latency: err_done / err_out / err_cnt update DW+2 edges after the accepting r_en edge.
// Backpressure: none; one request in flight at a time, new ones only on an r_en rising edge in READY.
//
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   en_err           - start pulse: latch b0/b1, clear counters, enter READY (aborts any sample)
//   b0, b1           - signed Q(DW-FW).FW intercept and slope
//   r_en, x_in, y_in - sample request (level, accepted on its rising edge) and its operands
//   err_done         - one-cycle completion pulse
//   err_out          - saturated residual, held until the next result
//   err_cnt          - completed samples since en_err, wraps
//   busy             - registered; high one edge after the datapath enters MUL, through SUB
//   err_acc          - saturating sum of |err_out|, only when ERR_ABS_ACC_EN is defined
//
// Optional feature macro: ERR_ABS_ACC_EN

module err_calc_resp #(
   parameter int DW = 20,
   parameter int FW = 10,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_err,
   input  logic [DW-1:0] b0,
   input  logic [DW-1:0] b1,
   input  logic          r_en,
   input  logic [DW-1:0] x_in,
   input  logic [DW-1:0] y_in,
   output logic          err_done,
   output logic [DW-1:0] err_out,
   output logic [CW-1:0] err_cnt,
   output logic          busy
`ifdef ERR_ABS_ACC_EN
   ,
   output logic [2*DW-1:0] err_acc
`endif
);

   localparam int SW = (DW > 1) ? $clog2(DW) : 1;

   // Saturation bounds for the shifted product (2*DW wide) and the residual (DW+2 wide).
   localparam logic signed [2*DW-1:0] PMAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [2*DW-1:0] PMIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
   localparam logic signed [DW+1:0]   EMAX = {3'b000, {(DW-1){1'b1}}};
   localparam logic signed [DW+1:0]   EMIN = {3'b111, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      MUL   = 2'd2,
      SUB   = 2'd3
   } state_t;

   state_t                 state;
   logic [DW-1:0]          b0_q;
   logic [DW-1:0]          b1_q;
   logic [DW-1:0]          y_q;
   logic                   r_en_q;
   logic [2*DW-1:0]        mcand;     // sign-extended b1, shifted left each step
   logic [DW-1:0]          mplier;    // x, shifted right each step
   logic signed [2*DW-1:0] prod;
   logic [SW-1:0]          step;
   logic                   done_pend; // result computed in SUB, published next edge
   logic [DW-1:0]          err_res;

   logic signed [2*DW-1:0] prod_sh;
   logic [DW-1:0]          prod_s;
   logic signed [DW+1:0]   diff;
   logic [DW-1:0]          err_sat;
   logic [2*DW-1:0]        addend;

   // Datapath for the SUB state and the current multiplier step.
   always_comb begin
      prod_sh = prod >>> FW;
      if (prod_sh > PMAX)
         prod_s = PMAX[DW-1:0];
      else if (prod_sh < PMIN)
         prod_s = PMIN[DW-1:0];
      else
         prod_s = prod_sh[DW-1:0];

      diff = {{2{y_q[DW-1]}}, y_q}
           - {{2{b0_q[DW-1]}}, b0_q}
           - {{2{prod_s[DW-1]}}, prod_s};
      if (diff > EMAX)
         err_sat = EMAX[DW-1:0];
      else if (diff < EMIN)
         err_sat = EMIN[DW-1:0];
      else
         err_sat = diff[DW-1:0];

      addend = mplier[0] ? mcand : '0;
   end

`ifdef ERR_ABS_ACC_EN
   logic [DW:0]     abs_err;
   logic [2*DW:0]   acc_sum;

   always_comb begin
      abs_err = {err_res[DW-1], err_res};
      if (abs_err[DW])
         abs_err = ~abs_err + 1'b1;
      acc_sum = {1'b0, err_acc} + {{DW{1'b0}}, abs_err};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_acc <= '0;
      end else if (en_err) begin
         err_acc <= '0;
      end else if (done_pend) begin
         err_acc <= acc_sum[2*DW] ? {(2*DW){1'b1}} : acc_sum[2*DW-1:0];
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         b0_q      <= '0;
         b1_q      <= '0;
         y_q       <= '0;
         r_en_q    <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
         step      <= '0;
         done_pend <= 1'b0;
         err_res   <= '0;
         err_done  <= 1'b0;
         err_out   <= '0;
         err_cnt   <= '0;
         busy      <= 1'b0;
      end else begin
         r_en_q   <= r_en;
         err_done <= 1'b0;
         busy     <= (state == MUL) || (state == SUB);

         // Output stage: publish the result computed in SUB on the previous edge.
         if (done_pend) begin
            err_out   <= err_res;
            err_done  <= 1'b1;
            err_cnt   <= err_cnt + 1'b1;
            done_pend <= 1'b0;
         end

         if (en_err) begin
            // Abort everything in flight; clearing r_en_q lets a still-high r_en
            // be accepted on the following edge.
            b0_q      <= b0;
            b1_q      <= b1;
            r_en_q    <= 1'b0;
            err_cnt   <= '0;
            err_done  <= 1'b0;
            done_pend <= 1'b0;
            busy      <= 1'b0;
            state     <= READY;
         end else begin
            case (state)
               IDLE: begin
                  state <= IDLE;
               end
               READY: begin
                  if (r_en && !r_en_q) begin
                     mcand  <= {{DW{b1_q[DW-1]}}, b1_q};
                     mplier <= x_in;
                     y_q    <= y_in;
                     prod   <= '0;
                     step   <= '0;
                     state  <= MUL;
                  end
               end
               MUL: begin
                  // MSB of a two's-complement multiplier carries negative weight.
                  if (step == SW'(DW-1)) begin
                     prod  <= prod - addend;
                     state <= SUB;
                  end else begin
                     prod <= prod + addend;
                  end
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  step   <= step + 1'b1;
               end
               SUB: begin
                  err_res   <= err_sat;
                  done_pend <= 1'b1;
                  state     <= READY;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
